// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage of the multicycle
// RISC-V core. It fetches one instruction over a req/ack handshake, holds it
// for the main FSM until iPCWrite, and then computes and loads the next PC.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, a target with bit 1
// set redirects to TRAP_VEC and pulses oMisalign for one cycle.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0040_0100
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iCTransf,
  input  logic [1:0]  iCOrigPC,
  input  logic [31:0] iImm,
  input  logic [31:0] iRs1,
  input  logic        iPCWrite,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [31:0] iMemRData,
  output logic [31:0] oInstr,
  output logic        oInstrValid,
  output logic [31:0] oPC,
  output logic [31:0] oPCPlus4,
  output logic        oMisalign
);

  typedef enum logic [0:0] {
    REQ  = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] target_s;
  logic [31:0] load_pc_s;
  logic        trap_hit_s;
  logic        ack_accept_s;

  // Next-PC selection: sequential, PC-relative (branch/jal) or register-based jalr.
  function automatic logic [31:0] calc_target(
    input logic        ctransf,
    input logic [1:0]  orig,
    input logic [31:0] pc,
    input logic [31:0] imm,
    input logic [31:0] rs1
  );
    logic [31:0] t;
    t = pc + 32'd4;
    if (ctransf) begin
      case (orig)
        2'b01:   t = pc + imm;
        2'b10:   t = pc + imm;
        2'b11:   t = (rs1 + imm) & ~32'h0000_0001;
        default: t = pc + 32'd4;  // 00 with a transfer is illegal: fall through sequentially
      endcase
    end else begin
      t = pc + 32'd4;
    end
    return t;
  endfunction

  // Target computation and optional misaligned-target redirect.
  always_comb begin
    target_s = calc_target(iCTransf, iCOrigPC, pc_q, iImm, iRs1);
`ifdef MISALIGN_TRAP_EN
    trap_hit_s = target_s[1];
    load_pc_s  = trap_hit_s ? TRAP_VEC : target_s;
`else
    trap_hit_s = 1'b0;
    load_pc_s  = target_s;
`endif
  end

  // An ack only counts while a request is actually being presented.
  assign ack_accept_s = (state_q == REQ) && req_q && iMemAck;

  // Next-state and register-update logic for the REQ/EXEC handshake FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = 1'b0;
    case (state_q)
      REQ: begin
        if (ack_accept_s) begin
          instr_d = iMemRData;
          state_d = EXEC;
        end else begin
          state_d = REQ;
        end
      end
      EXEC: begin
        // iPCWrite takes priority; a stray ack here is simply not looked at.
        if (iPCWrite) begin
          pc_d       = load_pc_s;
          misalign_d = trap_hit_s;
          state_d    = REQ;
        end else begin
          state_d = EXEC;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
    req_d   = (state_d == REQ);
    valid_d = (state_d == EXEC);
  end

  // State, PC, instruction register and registered handshake outputs.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign oMemReq     = req_q;
  assign oMemAddr    = pc_q;
  assign oInstr      = instr_q;
  assign oInstrValid = valid_q;
  assign oPC         = pc_q;
  assign oPCPlus4    = pc_q + 32'd4;
  assign oMisalign   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit. Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle after the
// active edge. Honors MISALIGN_TRAP_EN to pick the expected trap behaviour.
module tb_pc_fetch_unit;

  logic        iCLK = 1'b0;
  logic        iRSTn;
  logic        iCTransf;
  logic [1:0]  iCOrigPC;
  logic [31:0] iImm;
  logic [31:0] iRs1;
  logic        iPCWrite;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemAck;
  logic [31:0] iMemRData;
  logic [31:0] oInstr;
  logic        oInstrValid;
  logic [31:0] oPC;
  logic [31:0] oPCPlus4;
  logic        oMisalign;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCTransf(iCTransf), .iCOrigPC(iCOrigPC),
    .iImm(iImm), .iRs1(iRs1), .iPCWrite(iPCWrite), .oMemReq(oMemReq),
    .oMemAddr(oMemAddr), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oInstr(oInstr), .oInstrValid(oInstrValid), .oPC(oPC),
    .oPCPlus4(oPCPlus4), .oMisalign(oMisalign)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  // Stimulus helper: one-cycle iPCWrite pulse with the given transfer controls.
  task automatic pulse_pcwrite(input logic ct, input logic [1:0] orig,
                               input logic [31:0] imm, input logic [31:0] rs1);
    iCTransf = ct; iCOrigPC = orig; iImm = imm; iRs1 = rs1; iPCWrite = 1'b1;
    tick();
    iPCWrite = 1'b0; iCTransf = 1'b0; iCOrigPC = 2'b00; iImm = 32'd0; iRs1 = 32'd0;
  endtask

  // Stimulus helper: acknowledge the pending fetch with the given word.
  task automatic ack_fetch(input logic [31:0] data);
    iMemAck = 1'b1; iMemRData = data;
    tick();
    iMemAck = 1'b0; iMemRData = 32'd0;
  endtask

  task automatic test_reset();
    iRSTn = 1'b0; iCTransf = 1'b0; iCOrigPC = 2'b00; iImm = 32'd0; iRs1 = 32'd0;
    iPCWrite = 1'b0; iMemAck = 1'b0; iMemRData = 32'd0;
    repeat (2) tick();
    checks++; if (oMemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", oMemReq); end
    checks++; if (oInstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", oInstrValid); end
    checks++; if (oInstr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h want 00000013", oInstr); end
    checks++; if (oMemAddr !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc: got %h want 00400000", oMemAddr); end
    checks++; if (oMisalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", oMisalign); end
    iRSTn = 1'b1;
  endtask

  task automatic test_first_fetch();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (oMemReq !== 1'b1 || oMemAddr !== 32'h0040_0000 || oInstrValid !== 1'b0) begin
        errors++; $display("FAIL fetch_wait%0d: got req=%b addr=%h valid=%b want 1 00400000 0", i, oMemReq, oMemAddr, oInstrValid);
      end
    end
    ack_fetch(32'h0050_0093);
    checks++; if (oInstr !== 32'h0050_0093) begin errors++; $display("FAIL fetch_instr: got %h want 00500093", oInstr); end
    checks++; if (oInstrValid !== 1'b1 || oMemReq !== 1'b0) begin errors++; $display("FAIL fetch_exec: got valid=%b req=%b want 1 0", oInstrValid, oMemReq); end
    checks++; if (oPC !== 32'h0040_0000 || oPCPlus4 !== 32'h0040_0004) begin errors++; $display("FAIL fetch_pc: got %h/%h want 00400000/00400004", oPC, oPCPlus4); end
  endtask

  task automatic test_seq_and_branch();
    pulse_pcwrite(1'b0, 2'b01, 32'h0000_0100, 32'd0);
    checks++; if (oMemReq !== 1'b1 || oMemAddr !== 32'h0040_0004 || oInstrValid !== 1'b0) begin
      errors++; $display("FAIL seq_pc: got req=%b addr=%h valid=%b want 1 00400004 0", oMemReq, oMemAddr, oInstrValid);
    end
    ack_fetch(32'h1111_1111);
    pulse_pcwrite(1'b1, 2'b01, 32'hFFFF_FFF8, 32'd0);
    checks++; if (oMemAddr !== 32'h003F_FFFC) begin errors++; $display("FAIL branch_back: got %h want 003ffffc", oMemAddr); end
    ack_fetch(32'h2222_2222);
  endtask

  task automatic test_jalr_and_wrap();
    pulse_pcwrite(1'b1, 2'b11, 32'h0000_0002, 32'h1000_0003);
    checks++; if (oMemAddr !== 32'h1000_0004) begin errors++; $display("FAIL jalr_mask: got %h want 10000004", oMemAddr); end
    ack_fetch(32'h3333_3333);
    pulse_pcwrite(1'b1, 2'b11, 32'h0000_0000, 32'hFFFF_FFFC);
    ack_fetch(32'h4444_4444);
    checks++; if (oPC !== 32'hFFFF_FFFC || oPCPlus4 !== 32'h0000_0000) begin errors++; $display("FAIL top_pc: got %h/%h want fffffffc/00000000", oPC, oPCPlus4); end
    pulse_pcwrite(1'b1, 2'b10, 32'h0000_0008, 32'd0);
    checks++; if (oMemAddr !== 32'h0000_0004) begin errors++; $display("FAIL jal_wrap: got %h want 00000004", oMemAddr); end
    ack_fetch(32'h5555_5555);
    pulse_pcwrite(1'b1, 2'b00, 32'h0000_0100, 32'd0);
    checks++; if (oMemAddr !== 32'h0000_0008) begin errors++; $display("FAIL illegal_orig: got %h want 00000008", oMemAddr); end
    ack_fetch(32'h6666_6666);
  endtask

  task automatic test_stray_inputs();
    // Stray ack while executing.
    iMemAck = 1'b1; iMemRData = 32'hDEAD_BEEF;
    tick();
    iMemAck = 1'b0;
    checks++; if (oInstr !== 32'h6666_6666 || oInstrValid !== 1'b1 || oMemReq !== 1'b0 || oPC !== 32'h0000_0008) begin
      errors++; $display("FAIL stray_ack: got instr=%h valid=%b req=%b pc=%h want 66666666 1 0 00000008", oInstr, oInstrValid, oMemReq, oPC);
    end
    pulse_pcwrite(1'b0, 2'b00, 32'd0, 32'd0);
    // Stray iPCWrite while requesting.
    pulse_pcwrite(1'b1, 2'b10, 32'h0000_0100, 32'd0);
    checks++; if (oMemAddr !== 32'h0000_000C || oMemReq !== 1'b1 || oInstrValid !== 1'b0) begin
      errors++; $display("FAIL stray_pcwrite: got addr=%h req=%b valid=%b want 0000000c 1 0", oMemAddr, oMemReq, oInstrValid);
    end
    ack_fetch(32'h7777_7777);
    // iPCWrite and ack together in EXEC: only iPCWrite acts.
    iMemAck = 1'b1; iMemRData = 32'hBAD0_BAD0;
    pulse_pcwrite(1'b0, 2'b00, 32'd0, 32'd0);
    iMemAck = 1'b0;
    checks++; if (oInstr !== 32'h7777_7777 || oMemAddr !== 32'h0000_0010 || oMemReq !== 1'b1) begin
      errors++; $display("FAIL pcwrite_ack: got instr=%h addr=%h req=%b want 77777777 00000010 1", oInstr, oMemAddr, oMemReq);
    end
    // Reset in the middle of a pending request.
    iRSTn = 1'b0;
    #1;
    checks++; if (oMemReq !== 1'b0 || oMemAddr !== 32'h0040_0000) begin
      errors++; $display("FAIL reset_mid: got req=%b addr=%h want 0 00400000", oMemReq, oMemAddr);
    end
    @(negedge iCLK);
    iRSTn = 1'b1;
    tick();
    checks++; if (oMemReq !== 1'b1 || oMemAddr !== 32'h0040_0000 || oInstr !== 32'h0000_0013) begin
      errors++; $display("FAIL refetch: got req=%b addr=%h instr=%h want 1 00400000 00000013", oMemReq, oMemAddr, oInstr);
    end
  endtask

  task automatic test_misalign();
    ack_fetch(32'h8888_8888);
    pulse_pcwrite(1'b1, 2'b10, 32'h0000_0006, 32'd0);
`ifdef MISALIGN_TRAP_EN
    checks++; if (oMemAddr !== 32'h0040_0100 || oMisalign !== 1'b1) begin
      errors++; $display("FAIL trap_redirect: got addr=%h mis=%b want 00400100 1", oMemAddr, oMisalign);
    end
    tick();
    checks++; if (oMisalign !== 1'b0) begin errors++; $display("FAIL trap_pulse_len: got %b want 0", oMisalign); end
`else
    checks++; if (oMemAddr !== 32'h0040_0006 || oMisalign !== 1'b0) begin
      errors++; $display("FAIL no_trap: got addr=%h mis=%b want 00400006 0", oMemAddr, oMisalign);
    end
    tick();
    checks++; if (oMisalign !== 1'b0) begin errors++; $display("FAIL no_trap_hold: got %b want 0", oMisalign); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_seq_and_branch();
    test_jalr_and_wrap();
    test_stray_inputs();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the multicycle RISC-V core, directly downstream of the control-transfer decision logic.
- Consumes the take-transfer flag and PC-origin select, computes the next PC, and fetches the next instruction over a req/ack memory handshake.
- Holds the instruction register for the main control FSM until that FSM signals instruction completion.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
TRAP_VEC, 32'h0040_0100, PC loaded on a misaligned target (optional feature only).

Ports:
iCLK  in  1  system clock, rising edge
iRSTn  in  1  asynchronous active-low reset
iCTransf  in  1  take control transfer (from branch/jump decision)
iCOrigPC  in  2  00 normal, 01 branch, 10 jal, 11 jalr
iImm  in  32  sign-extended immediate of current instruction
iRs1  in  32  rs1 register value (jalr base)
iPCWrite  in  1  one-cycle pulse from main FSM: current instruction finished
oMemReq  out  1  instruction fetch request
oMemAddr  out  32  fetch address
iMemAck  in  1  memory accepted request, iMemRData valid this cycle
iMemRData  in  32  fetched instruction word
oInstr  out  32  instruction register
oInstrValid  out  1  oInstr holds a valid instruction for the FSM
oPC  out  32  PC of the instruction in oInstr
oPCPlus4  out  32  oPC+4 (link value for jal/jalr)
oMisalign  out  1  misaligned-target pulse (0 when feature compiled out)

Behaviour:
- Reset is asynchronous and active-low on iRSTn, with one clock iCLK.
- Reset values: PC=RESET_PC, oInstr=32'h0000_0013 (nop), oInstrValid=0, oMemReq=0, oMisalign=0, state=REQ.
- FSM states: REQ, EXEC.
- REQ:
  - oMemReq=1, oMemAddr=PC, oInstrValid=0.
  - Without iMemAck, stay in REQ and hold the address stable.
  - On iMemAck, latch iMemRData into oInstr and go to EXEC.
- EXEC:
  - oMemReq=0, oInstrValid=1.
  - oInstr, oPC and oPCPlus4 stay stable until iPCWrite.
  - On iPCWrite, load PC=next and go to REQ. oInstrValid drops in the following cycle.
- Latency: ack sampled at edge k gives oInstrValid=1 after edge k. iPCWrite at edge m gives oMemReq=1 with the new address after edge m.
- Minimum cycles per instruction in this stage: 2 (ack in the first REQ cycle, iPCWrite in the first EXEC cycle).
- Next-PC rule (32-bit, modulo 2^32, wrap-around silent):
  - iCTransf=0: PC+4.
  - iCTransf=1 with iCOrigPC 01 or 10: PC+iImm.
  - iCTransf=1 with iCOrigPC 11: (iRs1+iImm) & ~32'h1.
  - iCTransf=1 with iCOrigPC 00 is illegal: treat as PC+4.
- Ignored events:
  - iMemAck outside REQ.
  - iPCWrite outside EXEC (no PC change).
- Simultaneous events:
  - iPCWrite and a stray iMemAck in EXEC: only iPCWrite acts.
  - Reset asserted mid-handshake: reset wins, request dropped immediately (asynchronous), fetch restarts from RESET_PC after release.
- oPCPlus4 is combinational from oPC.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - On iPCWrite with a computed target where bit 1 = 1, PC loads TRAP_VEC instead of the target.
  - oMisalign pulses 1 for exactly one cycle, the cycle after the iPCWrite edge.
  - The check applies to the jalr target after bit-0 masking.
- Undefined:
  - The target is loaded unchanged and oMisalign is tied to 0.

Test Plan:
1. Reset release, memory acks after 3 cycles with 32'h00500093 -> oMemAddr=32'h0040_0000 for 3 cycles, then oInstr=32'h00500093 and oInstrValid=1 on the next cycle.
2. In EXEC: iPCWrite with iCTransf=0 -> next oMemAddr=32'h0040_0004. With iCTransf=1, iCOrigPC=01, iImm=-8 -> oMemAddr=32'h003F_FFFC.
3. Jalr: iRs1=32'h1000_0003, iImm=2, iCTransf=1, iCOrigPC=11 -> oMemAddr=32'h1000_0004 (bit 0 cleared). Jal at PC=32'hFFFF_FFFC with iImm=8 -> wraps to 32'h0000_0004.
4. Stray inputs: iMemAck in EXEC and iPCWrite in REQ -> oInstr, PC and state unchanged. iRSTn pulled low while oMemReq=1 -> oMemReq=0 immediately, refetch from RESET_PC after release.
5. With MISALIGN_TRAP_EN: jal, PC=32'h0040_0000, iImm=6 -> oMisalign=1 for one cycle, oMemAddr=TRAP_VEC. Without the macro -> oMemAddr=32'h0040_0006 and oMisalign=0.
